pim_dispatch_arbiter: RTL and testbench

Dispatches scheduler-issued PIM commands to one of NUM_EXEC PIM executors, sharing the executor pool between a single command stream. Sits between the local scheduler's EXECUTE stage and the executor array. Accepts one command per valid/ready handshake, selects a free executor round-robin, and drives a one-cycle start pulse with a registered operand bus. Tracks outstanding work per executor until its done pulse.

---
 rtl/pim_dispatch_pkg.sv | 26 ++
 rtl/pim_dispatch_arbiter_rr_pick.sv | 43 ++++
 rtl/pim_dispatch_arbiter.sv | 171 +++++++++++++++++
 tb/tb_pim_dispatch_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pim_dispatch_pkg
// Brief   : Shared dispatcher state encoding and the PIM op codes that the
//           scheduler decode also uses.
// Revision: 1.0
// ============================================================================
package pim_dispatch_pkg;

  localparam int c_OP_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_ISSUE = 2'd2
  } dispatch_state_t;

  localparam logic [c_OP_W-1:0] c_OP_NOP  = 5'h00;
  localparam logic [c_OP_W-1:0] c_OP_RD   = 5'h01;
  localparam logic [c_OP_W-1:0] c_OP_WR   = 5'h02;
  localparam logic [c_OP_W-1:0] c_OP_ADD  = 5'h08;
  localparam logic [c_OP_W-1:0] c_OP_MUL  = 5'h09;
  localparam logic [c_OP_W-1:0] c_OP_MAC  = 5'h14;

endpackage
`default_nettype wire

// File: rtl/pim_dispatch_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin selector: first request at or above
//           ptr, wrapping modulo N.
// Revision: 1.0
// ============================================================================
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Two descending passes: the last hit wins, so the j >= ptr group has priority.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j < int'(ptr))) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j >= int'(ptr))) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pim_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : pim_dispatch_arbiter
// Brief   : Dispatches one command stream round-robin onto NUM_EXEC PIM
//           executors. Optional watchdog: define PIM_DISPATCH_WDOG_EN.
// Revision: 1.0
// ============================================================================
module pim_dispatch_arbiter
  import pim_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 1024,
  parameter int NUM_EXEC       = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int AW = $clog2(BLOCK_SIZE),
  localparam int IW = (NUM_EXEC > 1) ? $clog2(NUM_EXEC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [c_OP_W-1:0]     cmd_op,
  input  logic [AW-1:0]         cmd_a1,
  input  logic [AW-1:0]         cmd_a2,
  input  logic [AW-1:0]         cmd_a3,
  input  logic [DATA_WIDTH-1:0] cmd_din,
  input  logic [NUM_EXEC-1:0]   exec_busy,
  input  logic [NUM_EXEC-1:0]   exec_done,
  output logic [NUM_EXEC-1:0]   exec_start,
  output logic [c_OP_W-1:0]     exec_op,
  output logic [AW-1:0]         exec_a1,
  output logic [AW-1:0]         exec_a2,
  output logic [AW-1:0]         exec_a3,
  output logic [DATA_WIDTH-1:0] exec_din,
  output logic                  all_idle,
  output logic [NUM_EXEC-1:0]   timeout_err
);

  dispatch_state_t       r_state;
  logic [c_OP_W-1:0]     r_hold_op, r_exec_op;
  logic [AW-1:0]         r_hold_a1, r_hold_a2, r_hold_a3;
  logic [AW-1:0]         r_exec_a1, r_exec_a2, r_exec_a3;
  logic [DATA_WIDTH-1:0] r_hold_din, r_exec_din;
  logic [NUM_EXEC-1:0]   r_pending, r_exec_start;
  logic [NUM_EXEC-1:0]   w_free, w_gnt, w_pending_next, w_timeout_err, w_wdog_clr;
  logic [IW-1:0]         r_rr_ptr, r_grant_idx, w_idx, w_ptr_next;
  logic                  w_any;

  assign w_free = ~exec_busy & ~r_pending & ~w_timeout_err;

  rr_pick #(
    .N  (NUM_EXEC),
    .IW (IW)
  ) u_rr_pick (
    .req (w_free),
    .ptr (r_rr_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_ptr_next = (r_grant_idx == IW'(NUM_EXEC - 1)) ? '0 : r_grant_idx + IW'(1);

  // The issue set uses the live start pulse, so it wins over a coincident done.
  always_comb begin
    w_pending_next = r_pending & ~exec_done & ~w_wdog_clr;
    if (r_state == ST_ISSUE) begin
      w_pending_next = w_pending_next | r_exec_start;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_hold_op    <= '0;
      r_hold_a1    <= '0;
      r_hold_a2    <= '0;
      r_hold_a3    <= '0;
      r_hold_din   <= '0;
      r_exec_op    <= '0;
      r_exec_a1    <= '0;
      r_exec_a2    <= '0;
      r_exec_a3    <= '0;
      r_exec_din   <= '0;
      r_exec_start <= '0;
      r_pending    <= '0;
      r_rr_ptr     <= '0;
      r_grant_idx  <= '0;
    end else begin
      r_pending <= w_pending_next;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_hold_op  <= cmd_op;
            r_hold_a1  <= cmd_a1;
            r_hold_a2  <= cmd_a2;
            r_hold_a3  <= cmd_a3;
            r_hold_din <= cmd_din;
            r_state    <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (w_any) begin
            r_grant_idx  <= w_idx;
            r_exec_start <= w_gnt;
            r_exec_op    <= r_hold_op;
            r_exec_a1    <= r_hold_a1;
            r_exec_a2    <= r_hold_a2;
            r_exec_a3    <= r_hold_a3;
            r_exec_din   <= r_hold_din;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_exec_start <= '0;
          r_rr_ptr     <= w_ptr_next;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_exec_start <= '0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PIM_DISPATCH_WDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  for (genvar i = 0; i < NUM_EXEC; i++) begin : g_wdog
    logic [CW-1:0] r_cnt;
    logic          r_err;

    assign w_wdog_clr[i]    = r_pending[i] & ~exec_done[i] & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_timeout_err[i] = r_err;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        if ((r_state == ST_ISSUE) && r_exec_start[i]) begin
          r_cnt <= '0;
        end else if (r_pending[i]) begin
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_wdog_clr[i]) begin
          r_err <= 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_wdog_clr       = '0;
  assign w_timeout_err    = '0;
`endif

  assign cmd_ready   = (r_state == ST_IDLE);
  assign all_idle    = (r_state == ST_IDLE) && !(|r_pending);
  assign exec_start  = r_exec_start;
  assign exec_op     = r_exec_op;
  assign exec_a1     = r_exec_a1;
  assign exec_a2     = r_exec_a2;
  assign exec_a3     = r_exec_a3;
  assign exec_din    = r_exec_din;
  assign timeout_err = w_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_pim_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_pim_dispatch_arbiter
// Brief   : Directed vector bench for pim_dispatch_arbiter (NUM_EXEC = 2).
// Revision: 1.0
// ============================================================================
module tb_pim_dispatch_arbiter;

  localparam int DW = 32;
  localparam int BS = 1024;
  localparam int NE = 2;
  localparam int AW = 10;
`ifdef PIM_DISPATCH_WDOG_EN
  localparam int TO = 8;
  localparam logic [1:0] c_EXP_ERR  = 2'b01;
  localparam logic       c_EXP_IDLE = 1'b1;
`else
  localparam int TO = 255;
  localparam logic [1:0] c_EXP_ERR  = 2'b00;
  localparam logic       c_EXP_IDLE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [4:0]    cmd_op, exec_op;
  logic [AW-1:0] cmd_a1, cmd_a2, cmd_a3, exec_a1, exec_a2, exec_a3;
  logic [DW-1:0] cmd_din, exec_din;
  logic [NE-1:0] exec_busy, exec_done, exec_start, timeout_err;
  logic          all_idle;

  always #5 clk = ~clk;

  pim_dispatch_arbiter #(
    .DATA_WIDTH     (DW),
    .BLOCK_SIZE     (BS),
    .NUM_EXEC       (NE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a1      (cmd_a1),
    .cmd_a2      (cmd_a2),
    .cmd_a3      (cmd_a3),
    .cmd_din     (cmd_din),
    .exec_busy   (exec_busy),
    .exec_done   (exec_done),
    .exec_start  (exec_start),
    .exec_op     (exec_op),
    .exec_a1     (exec_a1),
    .exec_a2     (exec_a2),
    .exec_a3     (exec_a3),
    .exec_din    (exec_din),
    .all_idle    (all_idle),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [4:0]    op;
    logic [AW-1:0] a1, a2, a3;
    logic [DW-1:0] din;
    logic [NE-1:0] busy;
    logic [NE-1:0] exp_start;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input vec_t v);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_a1    = v.a1;
    cmd_a2    = v.a2;
    cmd_a3    = v.a3;
    cmd_din   = v.din;
    exec_busy = v.busy;
  endtask

  // Full accept -> ARB -> ISSUE walk with all bus checks; optional done pulse.
  task automatic dispatch(input vec_t v, input bit do_done);
    offer(v);
    check("ready_idle", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    check("ready_arb", 64'(cmd_ready), 64'd0);
    check("start_arb", 64'(exec_start), 64'd0);
    step();
    check("start_issue", 64'(exec_start), 64'(v.exp_start));
    check("bus_op", 64'(exec_op), 64'(v.op));
    check("bus_a1", 64'(exec_a1), 64'(v.a1));
    check("bus_a2", 64'(exec_a2), 64'(v.a2));
    check("bus_a3", 64'(exec_a3), 64'(v.a3));
    check("bus_din", 64'(exec_din), 64'(v.din));
    check("ready_issue", 64'(cmd_ready), 64'd0);
    check("idle_issue", 64'(all_idle), 64'd0);
    exec_busy = '0;
    step();
    check("start_pulse_end", 64'(exec_start), 64'd0);
    check("bus_hold_op", 64'(exec_op), 64'(v.op));
    check("idle_pending", 64'(all_idle), 64'd0);
    if (do_done) begin
      exec_done = v.exp_start;
      step();
      exec_done = '0;
      check("idle_after_done", 64'(all_idle), 64'd1);
    end
  endtask

  initial begin
    vec_t v;

    vecs[0] = '{5'h14, 10'd3,  10'd7,  10'd9,  32'hA5A5_0001, 2'b00, 2'b01};
    vecs[1] = '{5'h01, 10'd11, 10'd12, 10'd13, 32'h0000_1111, 2'b00, 2'b10};
    vecs[2] = '{5'h02, 10'd21, 10'd22, 10'd23, 32'h2222_0000, 2'b00, 2'b01};
    vecs[3] = '{5'h08, 10'd31, 10'd32, 10'd33, 32'h3333_3333, 2'b10, 2'b01};
    vecs[4] = '{5'h09, 10'd41, 10'd42, 10'd43, 32'h4444_4444, 2'b01, 2'b10};
    vecs[5] = '{5'h1F, 10'd1023, 10'd0, 10'd512, 32'hFFFF_FFFF, 2'b01, 2'b10};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a1 = '0; cmd_a2 = '0; cmd_a3 = '0;
    cmd_din = '0; exec_busy = '0; exec_done = '0;
    step(); step();
    rst = 1'b0;
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_start", 64'(exec_start), 64'd0);
    check("rst_op", 64'(exec_op), 64'd0);
    check("rst_din", 64'(exec_din), 64'd0);
    check("rst_idle", 64'(all_idle), 64'd1);
    check("rst_err", 64'(timeout_err), 64'd0);

    // Table: round-robin wrap and busy masking, ends with rr_ptr = 0.
    for (int i = 0; i < 6; i++) dispatch(vecs[i], 1'b1);

    // Both busy for 10 cycles holds ARB; freeing exec 1 grants it next edge.
    v = '{5'h03, 10'd5, 10'd6, 10'd7, 32'h0BAD_CAFE, 2'b11, 2'b10};
    offer(v);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("busy_hold_start", 64'(exec_start), 64'd0);
      check("busy_hold_ready", 64'(cmd_ready), 64'd0);
      step();
    end
    exec_busy = 2'b01;
    step();
    check("busy_release_start", 64'(exec_start), 64'h2);
    exec_busy = '0;
    step();
    exec_done = 2'b10;
    step();
    exec_done = '0;
    check("busy_release_idle", 64'(all_idle), 64'd1);

    // Stray done with nothing pending.
    exec_done = 2'b10;
    step();
    exec_done = '0;
    check("stray_done_idle", 64'(all_idle), 64'd1);
    check("stray_done_ready", 64'(cmd_ready), 64'd1);
    check("stray_done_start", 64'(exec_start), 64'd0);

    // Done coinciding with ARB evaluation: exec 0 granted one cycle later.
    v = '{5'h0A, 10'd1, 10'd2, 10'd3, 32'h1234_5678, 2'b00, 2'b01};
    dispatch(v, 1'b0);
    v = '{5'h0B, 10'd4, 10'd5, 10'd6, 32'h8765_4321, 2'b10, 2'b01};
    offer(v);
    step();
    cmd_valid = 1'b0;
    exec_done = 2'b01;
    step();
    exec_done = '0;
    check("same_cycle_done_start", 64'(exec_start), 64'd0);
    check("same_cycle_done_ready", 64'(cmd_ready), 64'd0);
    step();
    check("same_cycle_done_grant", 64'(exec_start), 64'h1);
    check("same_cycle_done_op", 64'(exec_op), 64'h0B);
    exec_busy = '0;
    step();
    exec_done = 2'b01;
    step();
    exec_done = '0;
    check("same_cycle_done_idle", 64'(all_idle), 64'd1);

    // Reset while ARB holds a command.
    v = '{5'h0C, 10'd8, 10'd9, 10'd10, 32'hDEAD_BEEF, 2'b11, 2'b00};
    offer(v);
    step();
    cmd_valid = 1'b0;
    step();
    #1 rst = 1'b1;
    #1;
    check("midrst_ready", 64'(cmd_ready), 64'd1);
    check("midrst_start", 64'(exec_start), 64'd0);
    check("midrst_op", 64'(exec_op), 64'd0);
    check("midrst_a1", 64'(exec_a1), 64'd0);
    check("midrst_din", 64'(exec_din), 64'd0);
    check("midrst_idle", 64'(all_idle), 64'd1);
    check("midrst_err", 64'(timeout_err), 64'd0);
    #1 rst = 1'b0;
    exec_busy = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("postrst_no_start", 64'(exec_start), 64'd0);
    end
    v = '{5'h0D, 10'd100, 10'd200, 10'd300, 32'h0F0F_0F0F, 2'b00, 2'b01};
    dispatch(v, 1'b1);

    // Watchdog: exec 0 never completes; later commands must land on exec 1.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    v = '{5'h14, 10'd3, 10'd7, 10'd9, 32'hA5A5_0002, 2'b00, 2'b01};
    dispatch(v, 1'b0);
    for (int i = 0; i < 7; i++) step();
    check("wdog_before_limit", 64'(timeout_err), 64'd0);
    step();
    check("wdog_at_limit", 64'(timeout_err), 64'(c_EXP_ERR));
    check("wdog_idle", 64'(all_idle), 64'(c_EXP_IDLE));
    v = '{5'h01, 10'd1, 10'd1, 10'd1, 32'h0000_0001, 2'b00, 2'b10};
    dispatch(v, 1'b0);
    exec_done = 2'b10;
    step();
    exec_done = '0;
    v = '{5'h02, 10'd2, 10'd2, 10'd2, 32'h0000_0002, 2'b00, 2'b10};
    dispatch(v, 1'b0);
    exec_done = 2'b10;
    step();
    exec_done = '0;
    check("wdog_sticky", 64'(timeout_err), 64'(c_EXP_ERR));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
